// File: rtl/reg_to_axi_master.sv
// rtl/reg_to_axi_master.sv - register-bus initiator to single-beat AXI master bridge
package core_v_mcu_axi_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic        user;
    } aw_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic        user;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic       user;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic        user;
    } ar_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;
endpackage

package core_v_mcu_reg_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_resp_t;
endpackage

module reg_to_axi_master #(
    parameter int unsigned           AxiAddrWidth = 64,
    parameter int unsigned           AxiDataWidth = 64,
    parameter int unsigned           AxiIdWidth   = 4,
    parameter logic [AxiIdWidth-1:0] AxiId        = '0,
    parameter type axi_req_t  = core_v_mcu_axi_pkg::axi_req_t,
    parameter type axi_resp_t = core_v_mcu_axi_pkg::axi_resp_t,
    parameter type reg_req_t  = core_v_mcu_reg_pkg::reg_req_t,
    parameter type reg_resp_t = core_v_mcu_reg_pkg::reg_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  reg_req_t  reg_req_i,
    output reg_resp_t reg_rsp_o,
    output axi_req_t  axi_req_o,
    input  axi_resp_t axi_rsp_i,
    output logic      busy_o
);
    typedef enum logic [2:0] {
        IDLE, WRITE_REQ, WRITE_RSP, READ_REQ, READ_RSP, DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d, error_q, error_d;
    logic        aw_valid, w_valid, ar_valid, b_ready, r_ready;

    logic [AxiAddrWidth-1:0]   ax_addr;
    logic [AxiDataWidth-1:0]   w_data;
    logic [AxiDataWidth/8-1:0] w_strb;
    logic [31:0]               r_lane;

    assign ax_addr = AxiAddrWidth'({addr_q[31:2], 2'b00});

    // Narrow 32-bit accesses ride the lane picked by addr[2] on a 64-bit bus.
    if (AxiDataWidth == 64) begin : g_dw64
        assign w_data = {wdata_q, wdata_q};
        assign w_strb = addr_q[2] ? {wstrb_q, 4'h0} : {4'h0, wstrb_q};
        assign r_lane = addr_q[2] ? axi_rsp_i.r.data[63:32] : axi_rsp_i.r.data[31:0];
    end else begin : g_dw32
        assign w_data = wdata_q;
        assign w_strb = wstrb_q;
        assign r_lane = axi_rsp_i.r.data[31:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        ar_valid  = 1'b0;
        b_ready   = 1'b0;
        r_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (reg_req_i.valid) begin
                    addr_d    = reg_req_i.addr;
                    wdata_d   = reg_req_i.wdata;
                    wstrb_d   = reg_req_i.wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rdata_d   = '0;
                    error_d   = 1'b0;
                    state_d   = reg_req_i.write ? WRITE_REQ : READ_REQ;
                end
            end
            WRITE_REQ: begin
                // AW and W retire independently; move on once both have handshaken.
                aw_valid = !aw_done_q;
                w_valid  = !w_done_q;
                if (aw_valid && axi_rsp_i.aw_ready) aw_done_d = 1'b1;
                if (w_valid && axi_rsp_i.w_ready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = WRITE_RSP;
            end
            WRITE_RSP: begin
                b_ready = 1'b1;
                if (axi_rsp_i.b_valid) begin
                    error_d = axi_rsp_i.b.resp[1];
                    state_d = DONE;
                end
            end
            READ_REQ: begin
                ar_valid = 1'b1;
                if (axi_rsp_i.ar_ready) state_d = READ_RSP;
            end
            READ_RSP: begin
                r_ready = 1'b1;
                if (axi_rsp_i.r_valid) begin
                    rdata_d = r_lane;
                    error_d = axi_rsp_i.r.resp[1] | ~axi_rsp_i.r.last;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        axi_req_o             = '0;
        axi_req_o.aw.id       = AxiId;
        axi_req_o.aw.addr     = ax_addr;
        axi_req_o.aw.size     = 3'b010;
        axi_req_o.aw.burst    = 2'b01;
        axi_req_o.aw.cache    = 4'b0010;
        axi_req_o.aw_valid    = aw_valid;
        axi_req_o.w.data      = w_data;
        axi_req_o.w.strb      = w_strb;
        axi_req_o.w.last      = 1'b1;
        axi_req_o.w_valid     = w_valid;
        axi_req_o.b_ready     = b_ready;
        axi_req_o.ar.id       = AxiId;
        axi_req_o.ar.addr     = ax_addr;
        axi_req_o.ar.size     = 3'b010;
        axi_req_o.ar.burst    = 2'b01;
        axi_req_o.ar.cache    = 4'b0010;
        axi_req_o.ar_valid    = ar_valid;
        axi_req_o.r_ready     = r_ready;
    end

    assign reg_rsp_o.ready = (state_q == DONE);
    assign reg_rsp_o.rdata = (state_q == DONE) ? rdata_q : '0;
    assign reg_rsp_o.error = (state_q == DONE) ? error_q : 1'b0;
    assign busy_o          = (state_q != IDLE);

    logic unused_sigs;
    assign unused_sigs = ^{addr_q[1:0], axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.b.resp[0],
                           axi_rsp_i.r.id, axi_rsp_i.r.user, axi_rsp_i.r.resp[0]};
endmodule

// File: tb/tb_reg_to_axi_master.sv
// tb/tb_reg_to_axi_master.sv - directed vector bench for reg_to_axi_master
module tb_reg_to_axi_master;
    import core_v_mcu_axi_pkg::*;
    import core_v_mcu_reg_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    reg_req_t  reg_req;
    reg_resp_t reg_rsp;
    axi_req_t  axi_req;
    axi_resp_t axi_rsp;
    logic      busy;

    always #5 clk = ~clk;

    reg_to_axi_master dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .reg_req_i (reg_req),
        .reg_rsp_o (reg_rsp),
        .axi_req_o (axi_req),
        .axi_rsp_i (axi_rsp),
        .busy_o    (busy)
    );

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_lat, w_lat, ar_lat, r_lat, b_lat;
        logic [1:0]  resp;
        logic [63:0] rdata;
        bit          rlast;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wstrb;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    int          cfg_aw_lat = 0, cfg_w_lat = 0, cfg_ar_lat = 0, cfg_r_lat = 0, cfg_b_lat = 0;
    logic [1:0]  cfg_resp  = 2'd0;
    logic [63:0] cfg_rdata = '0;
    logic        cfg_rlast = 1'b1;
    bit          stale_b   = 1'b0;

    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0, stab_err = 0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    bit aw_hit = 0, w_hit = 0, b_owed = 0, r_owed = 0;
    bit aw_pend = 0, w_pend = 0, ar_pend = 0, br_pend = 0, rr_pend = 0;
    aw_chan_t aw_c, aw_prev;
    w_chan_t  w_c, w_prev;
    ar_chan_t ar_c, ar_prev;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] out_snap();
        return {24'h0, busy, reg_rsp.ready, reg_rsp.error, reg_rsp.rdata,
                axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, axi_req.b_ready, axi_req.r_ready};
    endfunction

    // Slave model: all decisions at negedge, handshakes land on the following posedge.
    initial begin
        axi_rsp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi_rsp = '0;
                axi_rsp.b_valid = stale_b;
                b_owed = 0; r_owed = 0; aw_hit = 0; w_hit = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
                aw_pend = 0; w_pend = 0; ar_pend = 0; br_pend = 0; rr_pend = 0;
            end else begin
                if (aw_pend && (!axi_req.aw_valid || axi_req.aw != aw_prev)) stab_err++;
                if (w_pend && (!axi_req.w_valid || axi_req.w != w_prev)) stab_err++;
                if (ar_pend && (!axi_req.ar_valid || axi_req.ar != ar_prev)) stab_err++;
                if (br_pend && !axi_req.b_ready) stab_err++;
                if (rr_pend && !axi_req.r_ready) stab_err++;

                axi_rsp.b_valid = stale_b;
                axi_rsp.b.resp  = cfg_resp;
                if (b_owed) begin
                    if (b_wait >= cfg_b_lat) begin
                        axi_rsp.b_valid = 1'b1;
                        if (axi_req.b_ready) begin b_owed = 0; b_cnt++; end
                    end else b_wait++;
                end
                br_pend = axi_req.b_ready && !axi_rsp.b_valid;

                axi_rsp.r_valid = 1'b0;
                axi_rsp.r.data  = cfg_rdata;
                axi_rsp.r.resp  = cfg_resp;
                axi_rsp.r.last  = cfg_rlast;
                if (r_owed) begin
                    if (r_wait >= cfg_r_lat) begin
                        axi_rsp.r_valid = 1'b1;
                        if (axi_req.r_ready) begin r_owed = 0; r_cnt++; end
                    end else r_wait++;
                end
                rr_pend = axi_req.r_ready && !axi_rsp.r_valid;

                axi_rsp.aw_ready = 1'b0; aw_pend = 0;
                if (axi_req.aw_valid) begin
                    if (aw_wait >= cfg_aw_lat) begin
                        axi_rsp.aw_ready = 1'b1; aw_wait = 0; aw_cnt++; aw_c = axi_req.aw; aw_hit = 1;
                    end else begin
                        aw_wait++; aw_pend = 1; aw_prev = axi_req.aw;
                    end
                end
                axi_rsp.w_ready = 1'b0; w_pend = 0;
                if (axi_req.w_valid) begin
                    if (w_wait >= cfg_w_lat) begin
                        axi_rsp.w_ready = 1'b1; w_wait = 0; w_cnt++; w_c = axi_req.w; w_hit = 1;
                    end else begin
                        w_wait++; w_pend = 1; w_prev = axi_req.w;
                    end
                end
                if (aw_hit && w_hit) begin aw_hit = 0; w_hit = 0; b_owed = 1; b_wait = 0; end
                axi_rsp.ar_ready = 1'b0; ar_pend = 0;
                if (axi_req.ar_valid) begin
                    if (ar_wait >= cfg_ar_lat) begin
                        axi_rsp.ar_ready = 1'b1; ar_wait = 0; ar_cnt++; ar_c = axi_req.ar;
                        r_owed = 1; r_wait = 0;
                    end else begin
                        ar_wait++; ar_pend = 1; ar_prev = axi_req.ar;
                    end
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int k, busy_bad, aw0, w0, ar0;
        bit seen;
        cfg_aw_lat = v.aw_lat; cfg_w_lat = v.w_lat; cfg_ar_lat = v.ar_lat;
        cfg_r_lat = v.r_lat; cfg_b_lat = v.b_lat;
        cfg_resp = v.resp; cfg_rdata = v.rdata; cfg_rlast = v.rlast;
        aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt;
        @(negedge clk);
        reg_req.addr = v.addr; reg_req.write = v.write; reg_req.wdata = v.wdata;
        reg_req.wstrb = v.wstrb; reg_req.valid = 1'b1;
        k = 0; seen = 0; busy_bad = 0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                reg_req.valid = 1'b0;
                reg_req.addr  = 32'hFFFF_FFFC;
                reg_req.wdata = ~v.wdata;
                reg_req.write = ~v.write;
            end
            if (!busy) busy_bad++;
            if (reg_rsp.ready) seen = 1;
        end
        check({tag, " ready_seen"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(k), 64'(v.exp_lat));
        check({tag, " busy_during"}, 64'(busy_bad), 64'd0);
        check({tag, " rdata"}, 64'(reg_rsp.rdata), 64'(v.exp_rdata));
        check({tag, " error"}, 64'(reg_rsp.error), 64'(v.exp_err));
        check({tag, " aw_beats"}, 64'(aw_cnt - aw0), v.write ? 64'd1 : 64'd0);
        check({tag, " w_beats"}, 64'(w_cnt - w0), v.write ? 64'd1 : 64'd0);
        check({tag, " ar_beats"}, 64'(ar_cnt - ar0), v.write ? 64'd0 : 64'd1);
        if (v.write) begin
            check({tag, " aw_addr"}, aw_c.addr, v.exp_addr);
            check({tag, " aw_ctrl"}, 64'({aw_c.len, aw_c.size, aw_c.burst, aw_c.cache, aw_c.id}),
                  64'({8'd0, 3'b010, 2'b01, 4'b0010, 4'd0}));
            check({tag, " w_data"}, w_c.data, v.exp_wdata);
            check({tag, " w_strb_last"}, 64'({w_c.strb, w_c.last}), 64'({v.exp_wstrb, 1'b1}));
        end else begin
            check({tag, " ar_addr"}, ar_c.addr, v.exp_addr);
            check({tag, " ar_ctrl"}, 64'({ar_c.len, ar_c.size, ar_c.burst, ar_c.cache, ar_c.id}),
                  64'({8'd0, 3'b010, 2'b01, 4'b0010, 4'd0}));
        end
        @(negedge clk);
        check({tag, " ready_one_cycle"}, 64'({reg_rsp.ready, busy}), 64'd0);
    endtask

    vec_t vecs[8];
    vec_t post_rst;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit seen;
        int ar0, b0;
        reg_req = '0;
        vecs[0] = '{1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'd0, 64'h0, 1'b1,
                    32'h0, 1'b0, 3, 64'h2000_0004, 64'hDEAD_BEEF_DEAD_BEEF, 8'hF0};
        vecs[1] = '{1'b0, 32'h2000_0000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd0, 64'h1111_2222_3333_4444, 1'b1,
                    32'h3333_4444, 1'b0, 3, 64'h2000_0000, 64'h0, 8'h00};
        vecs[2] = '{1'b0, 32'h2000_0004, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd2, 64'h1111_2222_3333_4444, 1'b1,
                    32'h1111_2222, 1'b1, 3, 64'h2000_0004, 64'h0, 8'h00};
        vecs[3] = '{1'b1, 32'h1000_0008, 32'h1234_5678, 4'h3, 3, 0, 0, 0, 0, 2'd3, 64'h0, 1'b1,
                    32'h0, 1'b1, 6, 64'h1000_0008, 64'h1234_5678_1234_5678, 8'h03};
        vecs[4] = '{1'b0, 32'h3000_0003, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0,
                    32'hCCCC_DDDD, 1'b1, 3, 64'h3000_0000, 64'h0, 8'h00};
        vecs[5] = '{1'b1, 32'h0000_0007, 32'hCAFE_F00D, 4'h0, 0, 0, 0, 0, 2, 2'd1, 64'h0, 1'b1,
                    32'h0, 1'b0, 5, 64'h0000_0004, 64'hCAFE_F00D_CAFE_F00D, 8'h00};
        vecs[6] = '{1'b0, 32'h8000_0004, 32'h0, 4'h0, 0, 0, 5, 7, 0, 2'd1, 64'h0123_4567_89AB_CDEF, 1'b1,
                    32'h0123_4567, 1'b0, 15, 64'h8000_0004, 64'h0, 8'h00};
        vecs[7] = '{1'b1, 32'h0000_0010, 32'h55AA_55AA, 4'h5, 0, 2, 0, 0, 0, 2'd2, 64'h0, 1'b1,
                    32'h0, 1'b1, 5, 64'h0000_0010, 64'h55AA_55AA_55AA_55AA, 8'h05};
        post_rst = '{1'b0, 32'h5000_0004, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd0, 64'hFEED_FACE_0BAD_F00D, 1'b1,
                     32'hFEED_FACE, 1'b0, 3, 64'h5000_0004, 64'h0, 8'h00};

        repeat (3) @(negedge clk);
        check("reset_outputs", out_snap(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", out_snap(), 64'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: a second request held while busy is taken only after ready.
        cfg_ar_lat = 5; cfg_r_lat = 7; cfg_resp = 2'd0; cfg_rlast = 1'b1;
        cfg_rdata = 64'h0A0A_0A0A_0B0B_0B0B;
        ar0 = ar_cnt;
        @(negedge clk);
        reg_req.addr = 32'h0000_1000; reg_req.write = 1'b0; reg_req.valid = 1'b1;
        k = 0; seen = 0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) reg_req.addr = 32'h0000_2004;
            if (reg_rsp.ready) seen = 1;
        end
        check("b2b first_latency", 64'(k), 64'd15);
        check("b2b first_rdata", 64'(reg_rsp.rdata), 64'h0B0B_0B0B);
        check("b2b ar_beats_first", 64'(ar_cnt - ar0), 64'd1);
        check("b2b first_ar_addr", ar_c.addr, 64'h1000);
        @(negedge clk);
        check("b2b ready_one_cycle", 64'(reg_rsp.ready), 64'd0);
        @(negedge clk);
        reg_req.valid = 1'b0;
        check("b2b second_accepted", 64'(busy), 64'd1);
        k = 0; seen = 0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            if (reg_rsp.ready) seen = 1;
        end
        check("b2b second_latency", 64'(k), 64'd14);
        check("b2b second_rdata", 64'(reg_rsp.rdata), 64'h0A0A_0A0A);
        check("b2b ar_beats_total", 64'(ar_cnt - ar0), 64'd2);
        check("b2b second_ar_addr", ar_c.addr, 64'h2004);
        @(negedge clk);

        // Reset while parked in WRITE_RSP, then a stale B during recovery.
        cfg_aw_lat = 0; cfg_w_lat = 0; cfg_b_lat = 50; cfg_resp = 2'd0;
        @(negedge clk);
        reg_req.addr = 32'h0000_0040; reg_req.write = 1'b1; reg_req.wdata = 32'h0F0F_0F0F;
        reg_req.wstrb = 4'hF; reg_req.valid = 1'b1;
        @(negedge clk);
        reg_req.valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid busy_b_ready", 64'({busy, axi_req.b_ready}), 64'b11);
        rst_n = 1'b0;
        stale_b = 1'b1;
        #1;
        check("rst_mid outputs_async", out_snap(), 64'd0);
        repeat (2) @(negedge clk);
        check("rst_mid outputs_held", out_snap(), 64'd0);
        b0 = b_cnt;
        rst_n = 1'b1;
        @(negedge clk);
        check("stale_b ignored", 64'({axi_req.b_ready, busy}), 64'd0);
        @(negedge clk);
        check("stale_b no_beat", 64'(b_cnt - b0), 64'd0);
        stale_b = 1'b0;
        run_vec(post_rst, "post_reset_read");

        check("valid_stability", 64'(stab_err), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
